// File: rtl/dense_layer_mac_seq.sv
// dense_layer_mac_seq
// Fully-connected layer y[o] = act(sum_i x[i]*w[o][i] + b[o]) on signed
// fixed-point data (FRAC fractional bits). LANES MACs are time-multiplexed
// over ceil(OUT_SIZE/LANES) output groups, one input element per cycle.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     request an evaluation (sampled in IDLE only)
//   act_mode  0 none, 1 ReLU, 2 leaky ReLU (s>>>3), 3 none; latched on start
//   x         input vector,  x[i]    = x[i*BITSIZE +: BITSIZE]
//   w         weights,       w[o][i] = w[(o*IN_SIZE+i)*BITSIZE +: BITSIZE]
//   b         biases,        b[o]    = b[o*BITSIZE +: BITSIZE]
//   busy      high from accepted start until done
//   done      one-cycle pulse, y complete
//   y         registered results, same packing as b
//
// state | meaning
// IDLE  | waiting for start
// MAC   | accumulate x[k]*w[o][k] for the current group, one k per cycle
// FIN   | add bias, rescale, saturate, activate, write y for the group
// DONE  | done pulse, back to IDLE next cycle
module dense_layer_mac_seq #(
    parameter int BITSIZE  = 16,
    parameter int FRAC     = 11,
    parameter int IN_SIZE  = 10,
    parameter int OUT_SIZE = 92,
    parameter int LANES    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [1:0]                      act_mode,
    input  logic [BITSIZE*IN_SIZE-1:0]          x,
    input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
    input  logic [BITSIZE*OUT_SIZE-1:0]         b,
    output logic                            busy,
    output logic                            done,
    output logic [BITSIZE*OUT_SIZE-1:0]     y
);
    localparam int GROUPS = (OUT_SIZE + LANES - 1) / LANES;
    localparam int ACC_W  = 2*BITSIZE + $clog2(IN_SIZE) + 1;
    localparam int K_W    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [BITSIZE-1:0] Y_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] Y_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [K_W-1:0]           k;
    logic [G_W-1:0]           grp;
    logic [1:0]               mode;
    logic signed [ACC_W-1:0]  acc  [LANES];
    logic signed [ACC_W-1:0]  prod [LANES];
    logic [BITSIZE*OUT_SIZE-1:0] y_nxt;
    logic                     last_k, last_grp;

    assign last_k   = (k == K_W'(IN_SIZE - 1));
    assign last_grp = (grp == G_W'(GROUPS - 1));

    // Product for output o at input index kk; lanes past OUT_SIZE contribute 0.
    function automatic logic signed [ACC_W-1:0] lane_prod(input int o, input int kk);
        logic [BITSIZE-1:0]      xv, wv;
        logic signed [ACC_W-1:0] xe, we;
        int                      wi;
        wi = (o < OUT_SIZE) ? (o*IN_SIZE + kk) : 0;
        xv = x[kk*BITSIZE +: BITSIZE];
        wv = w[wi*BITSIZE +: BITSIZE];
        xe = {{(ACC_W-BITSIZE){xv[BITSIZE-1]}}, xv};
        we = {{(ACC_W-BITSIZE){wv[BITSIZE-1]}}, wv};
        lane_prod = (o < OUT_SIZE) ? xe * we : '0;
    endfunction

    // Bias add, floor rescale, saturation and activation for one lane.
    function automatic logic [BITSIZE-1:0] finish_lane(input logic signed [ACC_W-1:0] a,
                                                       input logic [BITSIZE-1:0] bias,
                                                       input logic [1:0] m);
        logic signed [ACC_W:0] a_ext, b_ext, sum;
        logic [BITSIZE-1:0]    s;
        a_ext = {a[ACC_W-1], a};
        b_ext = {{(ACC_W+1-BITSIZE){bias[BITSIZE-1]}}, bias};
        sum   = (a_ext + (b_ext <<< FRAC)) >>> FRAC;
        // In range only if every bit above the result MSB matches the sign.
        if (sum[ACC_W:BITSIZE-1] != {(ACC_W-BITSIZE+2){sum[ACC_W]}})
            s = sum[ACC_W] ? Y_MIN : Y_MAX;
        else
            s = sum[BITSIZE-1:0];
        if (s[BITSIZE-1]) begin
            if (m == 2'd1)
                s = '0;
            else if (m == 2'd2)
                s = $signed(s) >>> 3;
        end
        finish_lane = s;
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++)
            prod[l] = lane_prod(int'(grp)*LANES + l, int'(k));
    end

    always_comb begin
        y_nxt = y;
        for (int l = 0; l < LANES; l++) begin
            if (int'(grp)*LANES + l < OUT_SIZE)
                y_nxt[(int'(grp)*LANES + l)*BITSIZE +: BITSIZE] =
                    finish_lane(acc[l], b[(int'(grp)*LANES + l)*BITSIZE +: BITSIZE], mode);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_MAC;
            S_MAC:   if (last_k) state_nxt = S_FIN;
            S_FIN:   state_nxt = last_grp ? S_DONE : S_MAC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            k     <= '0;
            grp   <= '0;
            mode  <= '0;
            for (int l = 0; l < LANES; l++)
                acc[l] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        mode <= act_mode;
                        k    <= '0;
                        grp  <= '0;
                        for (int l = 0; l < LANES; l++)
                            acc[l] <= '0;
                    end
                end
                S_MAC: begin
                    for (int l = 0; l < LANES; l++)
                        acc[l] <= acc[l] + prod[l];
                    if (!last_k)
                        k <= k + K_W'(1);
                end
                S_FIN: begin
                    y <= y_nxt;
                    k <= '0;
                    for (int l = 0; l < LANES; l++)
                        acc[l] <= '0;
                    if (last_grp) begin
                        grp  <= '0;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        grp <= grp + G_W'(1);
                    end
                end
                S_DONE: done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_mac_seq.sv
module tb_dense_layer_mac_seq;
    localparam int BS   = 16;
    localparam int IN   = 10;
    localparam int OUT  = 92;
    localparam int SOUT = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic start_s = 1'b0;
    logic [1:0] act_mode = 2'd0;
    logic [1:0] act_s = 2'd0;
    logic [BS*IN-1:0]       x;
    logic [BS*OUT*IN-1:0]   w;
    logic [BS*OUT-1:0]      b, y;
    logic [BS*SOUT*IN-1:0]  ws;
    logic [BS*SOUT-1:0]     bs, ys4, ys1;
    logic busy, done, busy4, done4, busy1, done1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dense_layer_mac_seq #(.BITSIZE(16), .FRAC(11), .IN_SIZE(IN), .OUT_SIZE(OUT), .LANES(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .act_mode(act_mode),
        .x(x), .w(w), .b(b), .busy(busy), .done(done), .y(y));

    dense_layer_mac_seq #(.BITSIZE(16), .FRAC(11), .IN_SIZE(IN), .OUT_SIZE(SOUT), .LANES(4)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .act_mode(act_s),
        .x(x), .w(ws), .b(bs), .busy(busy4), .done(done4), .y(ys4));

    dense_layer_mac_seq #(.BITSIZE(16), .FRAC(11), .IN_SIZE(IN), .OUT_SIZE(SOUT), .LANES(1)) u_one (
        .clk(clk), .reset(reset), .start(start_s), .act_mode(act_s),
        .x(x), .w(ws), .b(bs), .busy(busy1), .done(done1), .y(ys1));

    task automatic set_uniform(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
        for (int i = 0; i < IN; i++) x[i*BS +: BS] = xv;
        for (int i = 0; i < OUT*IN; i++) w[i*BS +: BS] = wv;
        for (int i = 0; i < OUT; i++) b[i*BS +: BS] = bv;
        for (int i = 0; i < SOUT*IN; i++) ws[i*BS +: BS] = wv;
        for (int i = 0; i < SOUT; i++) bs[i*BS +: BS] = bv;
    endtask

    // Start one run on the main instance and count edges until done (bounded).
    // act_mode is changed right after acceptance to show it was latched.
    task automatic run_main(output int lat);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        act_mode = act_mode ^ 2'b11;
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
        checks++; if ({busy4, done4, busy1, done1} !== 4'b0) begin errors++; $display("FAIL reset_small got %b want 0000", {busy4, done4, busy1, done1}); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        set_uniform(16'sd2048, 16'sd205, 16'sd1024);
        act_mode = 2'd0;
        run_main(lat);
        checks++; if (lat !== 253) begin errors++; $display("FAIL t1_latency got %0d want 253", lat); end
        for (int o = 0; o < OUT; o++) begin
            checks++;
            if (y[o*BS +: BS] !== 16'sd3074) begin errors++; $display("FAIL t1_y[%0d] got %0d want 3074", o, $signed(y[o*BS +: BS])); end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after got %b want 0", busy); end
    endtask

    task automatic test_round;
        int lat;
        set_uniform(16'sd2048, 16'sd205, 16'sd1024);
        x[1*BS +: BS] = 16'sd1024;
        act_mode = 2'd0;
        run_main(lat);
        checks++; if (lat !== 253) begin errors++; $display("FAIL t2_latency got %0d want 253", lat); end
        for (int o = 0; o < OUT; o++) begin
            checks++;
            if (y[o*BS +: BS] !== 16'sd2971) begin errors++; $display("FAIL t2_y[%0d] got %0d want 2971", o, $signed(y[o*BS +: BS])); end
        end
    endtask

    task automatic test_act;
        int lat;
        logic [15:0] expv [4];
        expv[0] = -16'sd2050; expv[1] = 16'sd0; expv[2] = -16'sd257; expv[3] = -16'sd2050;
        set_uniform(16'sd2048, -16'sd205, 16'sd0);
        for (int m = 0; m < 4; m++) begin
            act_mode = 2'(m);
            run_main(lat);
            checks++; if (lat !== 253) begin errors++; $display("FAIL t3_latency mode %0d got %0d want 253", m, lat); end
            for (int o = 0; o < OUT; o++) begin
                checks++;
                if (y[o*BS +: BS] !== expv[m]) begin errors++; $display("FAIL t3_y mode %0d [%0d] got %0d want %0d", m, o, $signed(y[o*BS +: BS]), $signed(expv[m])); end
            end
        end
    endtask

    task automatic test_saturation;
        int lat;
        set_uniform(16'sd32767, 16'sd32767, 16'sd32767);
        act_mode = 2'd0;
        run_main(lat);
        for (int o = 0; o < OUT; o++) begin
            checks++;
            if (y[o*BS +: BS] !== 16'sd32767) begin errors++; $display("FAIL t4_pos_y[%0d] got %0d want 32767", o, $signed(y[o*BS +: BS])); end
        end
        set_uniform(16'sd32767, 16'h8000, 16'h8000);
        act_mode = 2'd0;
        run_main(lat);
        for (int o = 0; o < OUT; o++) begin
            checks++;
            if (y[o*BS +: BS] !== 16'h8000) begin errors++; $display("FAIL t4_neg_y[%0d] got %0d want -32768", o, $signed(y[o*BS +: BS])); end
        end
    endtask

    task automatic test_ignore_start;
        int lat, pulses, first;
        set_uniform(16'sd2048, 16'sd205, 16'sd1024);
        act_mode = 2'd0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; pulses = 0; first = -1;
        while (lat < 262) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 50) start = 1'b1;
            if (lat == 51) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) first = lat;
            end
        end
        checks++; if (first !== 253) begin errors++; $display("FAIL t5_done_at got %0d want 253", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL t5_pulses got %0d want 1", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle_busy got %b want 0", busy); end
        checks++; if (y[0 +: BS] !== 16'sd3074) begin errors++; $display("FAIL t5_y0 got %0d want 3074", $signed(y[0 +: BS])); end
    endtask

    task automatic test_reset_mid;
        int lat;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t5_rst_done got %b want 0", done); end
        checks++; if (y !== '0) begin errors++; $display("FAIL t5_rst_y got %h want 0", y); end
        @(negedge clk); reset = 1'b1;
        act_mode = 2'd0;
        run_main(lat);
        checks++; if (lat !== 253) begin errors++; $display("FAIL t5_rerun_latency got %0d want 253", lat); end
        for (int o = 0; o < OUT; o++) begin
            checks++;
            if (y[o*BS +: BS] !== 16'sd3074) begin errors++; $display("FAIL t5_rerun_y[%0d] got %0d want 3074", o, $signed(y[o*BS +: BS])); end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        set_uniform(16'sd2048, 16'sd205, 16'sd1024);
        act_mode = 2'd0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 253) begin errors++; $display("FAIL b2b_first_latency got %0d want 253", lat); end
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_gap got busy,done=%b want 00", {busy, done}); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b want 1", busy); end
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 253) begin errors++; $display("FAIL b2b_second_latency got %0d want 253", lat); end
        checks++; if (y[91*BS +: BS] !== 16'sd3074) begin errors++; $display("FAIL b2b_y91 got %0d want 3074", $signed(y[91*BS +: BS])); end
    endtask

    task automatic test_small;
        int n, l4, l1;
        set_uniform(16'sd2048, 16'sd205, 16'sd1024);
        repeat (2) @(negedge clk);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        n = 0; l4 = -1; l1 = -1;
        while (n < 300 && l1 < 0) begin
            @(posedge clk); #1;
            n++;
            if (done4 === 1'b1 && l4 < 0) l4 = n;
            if (done1 === 1'b1 && l1 < 0) l1 = n;
        end
        checks++; if (l4 !== 33) begin errors++; $display("FAIL t6_lanes4_latency got %0d want 33", l4); end
        checks++; if (l1 !== 110) begin errors++; $display("FAIL t6_lanes1_latency got %0d want 110", l1); end
        for (int o = 0; o < SOUT; o++) begin
            checks++;
            if (ys4[o*BS +: BS] !== 16'sd3074) begin errors++; $display("FAIL t6_l4_y[%0d] got %0d want 3074", o, $signed(ys4[o*BS +: BS])); end
            checks++;
            if (ys1[o*BS +: BS] !== 16'sd3074) begin errors++; $display("FAIL t6_l1_y[%0d] got %0d want 3074", o, $signed(ys1[o*BS +: BS])); end
        end
    endtask

    initial begin
        set_uniform(16'sd0, 16'sd0, 16'sd0);
        test_reset;
        test_basic;
        test_round;
        test_act;
        test_saturation;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_small;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
